// File: rtl/ofm_writer.sv
// Output-feature-map writer: streams one tile of TM*OFM_SIZE words from the on-chip
// OFM buffer to contiguous SDRAM words, with optional ReLU clamping of negative words.
module ofm_writer #(
    parameter int               DATA_W   = 32,
    parameter int               ADR_W    = 32,
    parameter int               OFM_SIZE = 784,
    parameter int               TM       = 4,
    parameter int               M_W      = 8,
    parameter logic [ADR_W-1:0] OUT_BASE = {ADR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [M_W-1:0]    m,
    input  logic              relu_en,
    output logic [ADR_W-1:0]  buf_rd_addr,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic              SDRAM_WE_N,
    output logic [ADR_W-1:0]  SDRAM_ADDR,
    output logic [DATA_W-1:0] SDRAM_WRITEDATA,
    input  logic              SDRAM_WAIT,
    output logic              busy,
    output logic              done
);

    localparam int TOTAL = TM * OFM_SIZE;
    localparam int K_W   = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [K_W-1:0]     k_r;
    logic [M_W-1:0]     m_r;
    logic               relu_r;
    logic [ADR_W-1:0]   addr_r;
    logic               accept_s;
    logic               last_s;
    logic [ADR_W-1:0]   base_s;

    function automatic logic [DATA_W-1:0] relu_clamp(input logic [DATA_W-1:0] w,
                                                     input logic              en);
        if (en && w[DATA_W-1]) begin
            relu_clamp = {DATA_W{1'b0}};
        end else begin
            relu_clamp = w;
        end
    endfunction

    assign accept_s = (state_r == WRITE) && !SDRAM_WAIT;
    assign last_s   = (k_r == K_W'(TOTAL - 1));
    // Modulo-2^ADR_W arithmetic keeps the tile base wrapping cleanly at the top of memory.
    assign base_s   = OUT_BASE + (ADR_W'(m_r) * ADR_W'(OFM_SIZE));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = PRIME;
                end else begin
                    state_s = IDLE;
                end
            end
            PRIME: state_s = WRITE;
            WRITE: begin
                if (accept_s && last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = WRITE;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Tile context, word index and SDRAM address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_r    <= {K_W{1'b0}};
            m_r    <= {M_W{1'b0}};
            relu_r <= 1'b0;
            addr_r <= {ADR_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        m_r    <= m;
                        relu_r <= relu_en;
                        k_r    <= {K_W{1'b0}};
                    end
                end
                PRIME: addr_r <= base_s;
                WRITE: begin
                    // The final accepted word leaves k and the address parked on it.
                    if (accept_s && !last_s) begin
                        k_r    <= k_r + K_W'(1);
                        addr_r <= addr_r + ADR_W'(1);
                    end
                end
                default: begin
                    k_r <= k_r;
                end
            endcase
        end
    end

    // Status, write strobe and buffer prefetch address.
    always_comb begin
        SDRAM_WE_N  = 1'b1;
        busy        = 1'b1;
        done        = 1'b0;
        // Look one word ahead on acceptance so the next word arrives with the next write.
        buf_rd_addr = ADR_W'(k_r) + ADR_W'(accept_s);
        case (state_r)
            IDLE:    busy       = 1'b0;
            PRIME:   SDRAM_WE_N = 1'b1;
            WRITE:   SDRAM_WE_N = 1'b0;
            DONE:    done       = 1'b1;
            default: busy       = 1'b0;
        endcase
    end

    assign SDRAM_ADDR      = addr_r;
    assign SDRAM_WRITEDATA = relu_clamp(buf_rd_data, relu_r);

endmodule
